// File: rtl/stream_sink_checker.sv
// Stream sink: drives ready with a backpressure pattern, checks for an incrementing data
// sequence and flags source protocol violations. Define HS_SINK_LFSR_READY_EN for LFSR-driven ready.
module stream_sink_checker #(
   parameter int WIDTH     = 32,
   parameter int PAT_LEN   = 8,
   parameter int NUM_BEATS = 16,
   parameter int CNT_W     = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [WIDTH-1:0]   data_in,
   input  logic               up_valid_in,
   output logic               up_ready_out,
   input  logic               start,
   input  logic [WIDTH-1:0]   start_value,
   input  logic [PAT_LEN-1:0] stall_pattern,
   output logic [CNT_W-1:0]   beat_count,
   output logic [CNT_W-1:0]   err_count,
   output logic               seq_err,
   output logic               proto_err,
   output logic               done
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   exp_q, exp_d;
   logic [CNT_W-1:0]   beat_q, beat_d;
   logic [CNT_W-1:0]   err_q, err_d;
   logic               seq_err_q, seq_err_d;
   logic               proto_err_q, proto_err_d;
   logic               prev_valid_q;
   logic               prev_fire_q;
   logic [WIDTH-1:0]   prev_data_q;
   logic               ready_w;
   logic               fire_w;

`ifdef HS_SINK_LFSR_READY_EN
   logic [15:0]        lfsr_q, lfsr_d;
   logic               lfsr_fb_w;

   assign lfsr_fb_w = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
   assign ready_w   = (state_q == ST_RUN) & (lfsr_q[0] | lfsr_q[1]);
`else
   localparam int PTR_W = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;

   logic [PAT_LEN-1:0] pat_q, pat_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;

   assign ready_w = (state_q == ST_RUN) & pat_q[ptr_q];
`endif

   // Ready depends only on registered state, so there is no input-to-ready path.
   assign up_ready_out = ready_w;
   assign fire_w       = up_valid_in & ready_w;

   always_comb begin
      state_d   = state_q;
      exp_d     = exp_q;
      beat_d    = beat_q;
      err_d     = err_q;
      seq_err_d = seq_err_q;
`ifdef HS_SINK_LFSR_READY_EN
      lfsr_d    = lfsr_q;
`else
      pat_d     = pat_q;
      ptr_d     = ptr_q;
`endif
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d   = ST_RUN;
               exp_d     = start_value;
               beat_d    = '0;
               err_d     = '0;
               seq_err_d = 1'b0;
`ifdef HS_SINK_LFSR_READY_EN
               lfsr_d    = 16'hACE1;
`else
               pat_d     = stall_pattern;
               ptr_d     = '0;
`endif
            end
         end
         ST_RUN: begin
`ifdef HS_SINK_LFSR_READY_EN
            lfsr_d = {lfsr_q[14:0], lfsr_fb_w};
`else
            ptr_d = (ptr_q == PTR_W'(PAT_LEN - 1)) ? '0 : ptr_q + 1'b1;
`endif
            if (fire_w) begin
               beat_d = beat_q + 1'b1;
               if (data_in != exp_q) begin
                  if (err_q != {CNT_W{1'b1}}) begin
                     err_d = err_q + 1'b1;
                  end
                  seq_err_d = 1'b1;
               end
               // Resync on the received value so one bad beat costs exactly one error.
               exp_d = data_in + 1'b1;
               if (beat_q == CNT_W'(NUM_BEATS - 1)) begin
                  state_d = ST_DONE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // A stalled beat must be held with unchanged data until it is accepted.
   assign proto_err_d = proto_err_q |
                        (prev_valid_q & ~prev_fire_q &
                         (~up_valid_in | (data_in != prev_data_q)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         exp_q        <= '0;
         beat_q       <= '0;
         err_q        <= '0;
         seq_err_q    <= 1'b0;
         proto_err_q  <= 1'b0;
         prev_valid_q <= 1'b0;
         prev_fire_q  <= 1'b0;
         prev_data_q  <= '0;
`ifdef HS_SINK_LFSR_READY_EN
         lfsr_q       <= 16'hACE1;
`else
         pat_q        <= '0;
         ptr_q        <= '0;
`endif
      end else begin
         state_q      <= state_d;
         exp_q        <= exp_d;
         beat_q       <= beat_d;
         err_q        <= err_d;
         seq_err_q    <= seq_err_d;
         proto_err_q  <= proto_err_d;
         prev_valid_q <= up_valid_in;
         prev_fire_q  <= fire_w;
         prev_data_q  <= data_in;
`ifdef HS_SINK_LFSR_READY_EN
         lfsr_q       <= lfsr_d;
`else
         pat_q        <= pat_d;
         ptr_q        <= ptr_d;
`endif
      end
   end

   assign beat_count = beat_q;
   assign err_count  = err_q;
   assign seq_err    = seq_err_q;
   assign proto_err  = proto_err_q;
   assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_stream_sink_checker.sv
// Directed bench for stream_sink_checker: table of whole-run vectors plus hand-written
// sequences for restart, mid-run reset, all-zero stall and protocol violation.
module tb_stream_sink_checker;

   localparam int NB = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] data_in;
   logic        up_valid_in;
   logic        up_ready_out;
   logic        start;
   logic [31:0] start_value;
   logic [7:0]  stall_pattern;
   logic [15:0] beat_count;
   logic [15:0] err_count;
   logic        seq_err;
   logic        proto_err;
   logic        done;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [7:0]  pat;
      logic [31:0] sv;
      int          jidx;      // beat index where the source jumps ahead
      logic [31:0] jump;
      bit          sol;       // pulse start together with the final fire
      int          exp_cyc;   // RUN cycles up to and including the final fire
      int          exp_err;
   } vec_t;

   vec_t vecs[7];

   stream_sink_checker #(.WIDTH(32), .PAT_LEN(8), .NUM_BEATS(NB), .CNT_W(16)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .data_in      (data_in),
      .up_valid_in  (up_valid_in),
      .up_ready_out (up_ready_out),
      .start        (start),
      .start_value  (start_value),
      .stall_pattern(stall_pattern),
      .beat_count   (beat_count),
      .err_count    (err_count),
      .seq_err      (seq_err),
      .proto_err    (proto_err),
      .done         (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s/%s: got %0h, expected %0h", tag, name, act, exp);
      end else begin
         $display("[TB] ok %s/%s = %0h", tag, name, act);
      end
   endtask

   function automatic logic [31:0] gen(input vec_t v, input int k);
      return v.sv + 32'(k) + ((k >= v.jidx) ? v.jump : 32'd0);
   endfunction

   task automatic run_vec(input vec_t v, input logic exp_proto, input string tag);
      int   k;
      int   cyc;
      logic f;
      @(negedge clk);
      start = 1'b1; start_value = v.sv; stall_pattern = v.pat;
      @(posedge clk); #1;
      start = 1'b0; up_valid_in = 1'b1; data_in = gen(v, 0);
      k = 0; cyc = 0;
      while (k < NB && cyc < 400) begin
         @(negedge clk);
         f = up_valid_in & up_ready_out;
         cyc++;
         if (f && k == NB - 1 && v.sol) start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         if (f) begin
            k++;
            data_in = gen(v, k);
            if (k == NB) up_valid_in = 1'b0;
         end
      end
      if (k < NB) chk(tag, "beats_before_timeout", k, NB);
`ifndef HS_SINK_LFSR_READY_EN
      chk(tag, "cycles", cyc, v.exp_cyc);
`endif
      @(negedge clk);
      chk(tag, "done", done, 1'b1);
      chk(tag, "beat_count", beat_count, NB);
      chk(tag, "err_count", err_count, v.exp_err);
      chk(tag, "seq_err", seq_err, (v.exp_err != 0));
      chk(tag, "proto_err", proto_err, exp_proto);
      chk(tag, "ready_done", up_ready_out, 1'b0);
      @(negedge clk);
      chk(tag, "done_hold", done, 1'b1);
      chk(tag, "beat_hold", beat_count, NB);
   endtask

   initial begin
      int k;
      int cyc;
      vecs[0] = '{8'hFF, 32'd0,          99, 32'd0, 1'b0, 16,  0};
      vecs[1] = '{8'hAA, 32'd100,        99, 32'd0, 1'b0, 32,  0};
      vecs[2] = '{8'h55, 32'h1234,       99, 32'd0, 1'b0, 31,  0};
      vecs[3] = '{8'h01, 32'd0,          99, 32'd0, 1'b0, 121, 0};
      vecs[4] = '{8'hFF, 32'hFFFF_FFFE,  99, 32'd0, 1'b0, 16,  0};
      vecs[5] = '{8'hFF, 32'd50,         99, 32'd0, 1'b1, 16,  0};
      vecs[6] = '{8'hFF, 32'd5,          2,  32'd2, 1'b0, 16,  1};

      rst_n = 1'b0; data_in = '0; up_valid_in = 1'b0; start = 1'b0;
      start_value = '0; stall_pattern = '0;
      #1;
      chk("reset", "ready", up_ready_out, 1'b0);
      chk("reset", "beat_count", beat_count, 0);
      chk("reset", "err_count", err_count, 0);
      chk("reset", "flags", {seq_err, proto_err, done}, 3'b000);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 7; i++) begin
         run_vec(vecs[i], 1'b0, $sformatf("vec%0d", i));
      end

      // Restart from DONE clears the run state left by the error run.
      @(negedge clk);
      start = 1'b1; start_value = 32'd200; stall_pattern = 8'hFF;
      @(posedge clk); #1;
      start = 1'b0;
      chk("restart", "beat_count", beat_count, 0);
      chk("restart", "err_count", err_count, 0);
      chk("restart", "seq_err", seq_err, 1'b0);
      chk("restart", "done", done, 1'b0);
      chk("restart", "ready", up_ready_out, 1'b1);

      // Five beats, then an asynchronous reset in the middle of a cycle.
      up_valid_in = 1'b1; data_in = 32'd200; k = 0; cyc = 0;
      while (k < 5 && cyc < 50) begin
         @(posedge clk); #1;
         cyc++;
         k++;
         data_in = 32'd200 + 32'(k);
      end
      chk("midreset", "beat_before", beat_count, 5);
      #2 rst_n = 1'b0;
      #1;
      chk("midreset", "ready", up_ready_out, 1'b0);
      chk("midreset", "beat_count", beat_count, 0);
      chk("midreset", "err_count", err_count, 0);
      chk("midreset", "flags", {seq_err, proto_err, done}, 3'b000);
      up_valid_in = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("midreset", "idle_ready", up_ready_out, 1'b0);

      // All-zero pattern stalls forever; then a dropped stalled beat is a violation.
      @(negedge clk);
      start = 1'b1; start_value = 32'd0; stall_pattern = 8'h00;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("stall", "beat_count", beat_count, 0);
      chk("stall", "done", done, 1'b0);
      chk("stall", "ready", up_ready_out, 1'b0);
      up_valid_in = 1'b1; data_in = 32'd7;
      repeat (3) @(posedge clk);
      #1;
      up_valid_in = 1'b0;
      chk("proto", "before_drop", proto_err, 1'b0);
      @(posedge clk); #1;
      chk("proto", "after_drop", proto_err, 1'b1);
      repeat (5) @(posedge clk);
      #1;
      chk("proto", "sticky", proto_err, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("proto", "cleared_by_reset", proto_err, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Data change while stalled in IDLE; the flag must survive a later start.
      @(posedge clk); #1;
      up_valid_in = 1'b1; data_in = 32'd3;
      @(posedge clk); #1;
      data_in = 32'd4;
      @(posedge clk); #1;
      up_valid_in = 1'b0;
      chk("proto_idle", "set", proto_err, 1'b1);
      run_vec(vecs[0], 1'b1, "proto_keep");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
